mem_port_arbiter: RTL

//  Shares one unified single-port RAM between the IF stage (instruction fetch) and the
//  MEM stage (load/store) of the 5-stage MIPS pipeline. It grants one access at a time,

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_access_timer.sv | 31 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-RAM port arbiter: FSM encodings,
// grant identifiers and the word returned when an access times out.
package mem_port_arbiter_pkg;

    // FSM state encodings (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_ACC  = 3'd1;
    localparam logic [2:0] ST_D_ACC  = 3'd2;
    localparam logic [2:0] ST_I_DONE = 3'd3;
    localparam logic [2:0] ST_D_DONE = 3'd4;

    // Identifies which port was served last (round-robin pointer)
    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    // Word loaded into the read register when the RAM never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    // True while the RAM port is being driven
    function automatic logic is_acc(input logic [2:0] st);
        return (st == ST_I_ACC) || (st == ST_D_ACC);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// Access watchdog counter: held at zero outside an access, counts the
// cycles an access waits for the RAM, and flags the wait that reaches MAX.
module access_timer #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count;

    // Load-to-zero has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count: this un-answered cycle is the MAX-th one of the access
    assign tc = inc && (count == CW'(MAX - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store.
// One access at a time, round-robin when both ports ask in the same cycle,
// registered read data, combinational stalls, and a watchdog so a silent
// RAM cannot hang the pipeline.
//
// Handshake: a requester raises its request and holds it (with address and
// data) stable while its stall is high; the stall drops for exactly one cycle
// (the DONE state) in which the registered read data is valid. On the RAM
// side ram_cs/ram_we/ram_addr/ram_wdata are held during an ACC state until
// the cycle in which ram_ready=1, which completes the access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_ren,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_stall,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              data_stall,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              err_timeout,
    output logic [2:0]        dbg_state
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_grant;
    logic       ireq;
    logic       dreq;
    logic       in_acc;
    logic       timer_tc;
    logic       acc_end;

    assign ireq    = inst_ren;
    assign dreq    = mem_ren | mem_wen;
    assign in_acc  = is_acc(state);
    // An access ends on ram_ready or when the watchdog gives up
    assign acc_end = in_acc && (ram_ready || timer_tc);

    access_timer #(
        .MAX (WAIT_MAX)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!in_acc),
        .inc   (in_acc && !ram_ready),
        .tc    (timer_tc)
    );

    // Next-state logic with round-robin tie break in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (dreq && ireq) begin
                    state_nxt = (last_grant == GRANT_INST) ? ST_D_ACC : ST_I_ACC;
                end else if (dreq) begin
                    state_nxt = ST_D_ACC;
                end else if (ireq) begin
                    state_nxt = ST_I_ACC;
                end
            end
            ST_I_ACC:  if (acc_end) state_nxt = ST_I_DONE;
            ST_D_ACC:  if (acc_end) state_nxt = ST_D_DONE;
            ST_I_DONE: state_nxt = ST_IDLE;
            ST_D_DONE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_INST;
        end else begin
            state <= state_nxt;
            if (acc_end) begin
                last_grant <= (state == ST_D_ACC) ? GRANT_DATA : GRANT_INST;
            end
        end
    end

    // Read-data registers; stores (including ren&wen) never touch mem_din
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_data <= '0;
            mem_din   <= '0;
        end else begin
            if (state == ST_I_ACC) begin
                if (ram_ready) begin
                    inst_data <= ram_rdata;
                end else if (timer_tc) begin
                    inst_data <= DATA_W'(TIMEOUT_DATA);
                end
            end
            if (state == ST_D_ACC && !mem_wen) begin
                if (ram_ready) begin
                    mem_din <= ram_rdata;
                end else if (timer_tc) begin
                    mem_din <= DATA_W'(TIMEOUT_DATA);
                end
            end
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (timer_tc) begin
            err_timeout <= 1'b1;
        end
    end

    // RAM port drive; decoded from state so it drops as soon as reset asserts
    always_comb begin
        ram_cs    = in_acc;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == ST_I_ACC) begin
            ram_addr = inst_addr;
        end else if (state == ST_D_ACC) begin
            ram_addr  = mem_addr;
            ram_we    = mem_wen;
            ram_wdata = mem_dout;
        end
    end

    // Stalls release only in the requester's own DONE cycle
    assign inst_stall = ireq && (state != ST_I_DONE);
    assign data_stall = dreq && (state != ST_D_DONE);
    assign dbg_state  = state;

endmodule
